// File: rtl/rr_resource_arbiter.sv
`default_nettype none
// ==== rr_resource_arbiter: round-robin single-owner grant with hold limit and settle gap ====
// ==== Revision: 1.0 ====
module rr_resource_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int MAXHOLD = 16,
  parameter  int GAP     = 1,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            release_i,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  output logic            timeout,
  output logic            busy
);

  localparam int HW = $clog2(MAXHOLD);
  localparam int GW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWNED  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [IDW-1:0]  id_nxt;
  logic            timeout_nxt;
  logic [IDW-1:0]  pick, idx;
  logic            pick_found;
  logic            early_end, hold_last;

  // Descending scan so the lowest rotation offset from ptr wins.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        pick       = idx;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    gap_nxt     = gap_cnt;
    gnt_nxt     = gnt;
    id_nxt      = gnt_id;
    timeout_nxt = 1'b0;
    early_end   = release_i || !req[gnt_id];
    hold_last   = (hold_cnt == HW'(MAXHOLD - 1));
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          gnt_nxt   = NREQ'(1) << pick;
          id_nxt    = pick;
          hold_nxt  = '0;
          state_nxt = OWNED;
        end
      end
      OWNED: begin
        if (early_end || hold_last) begin
          gnt_nxt     = '0;
          id_nxt      = '0;
          ptr_nxt     = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
          gap_nxt     = '0;
          timeout_nxt = hold_last && !early_end;
          state_nxt   = SETTLE;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (gap_cnt == GW'(GAP - 1)) begin
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        id_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gap_cnt   <= gap_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= |gnt_nxt;
      gnt_id    <= id_nxt;
      timeout   <= timeout_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  a_onehot:  assert property (@(posedge clock) disable iff (!reset) $onehot0(gnt));
  a_valid:   assert property (@(posedge clock) disable iff (!reset) gnt_valid == (|gnt));
  a_owned:   assert property (@(posedge clock) disable iff (!reset) (gnt != '0) |-> (state == OWNED));
  a_timeout: assert property (@(posedge clock) disable iff (!reset) timeout |-> ($past(state) == OWNED));

endmodule
`default_nettype wire
